// File: rtl/mem_responder_pkg.sv
// Shared encodings and widths for the memory responder and its hit buffer.
// Pure definitions plus a small request-legality helper used by the FSM.
package mem_responder_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    // A request is rejected when both ops are asked for or the address is odd.
    function automatic logic req_bad(input logic rd, input logic wr, input logic a0);
        return (rd & wr) | ((rd | wr) & a0);
    endfunction

endpackage

// File: rtl/mem_hit_buffer.sv
// Single-entry read hit buffer: filled by completing reads, kept coherent
// by completing writes to the same word.
module mem_hit_buffer
    import mem_responder_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     lookup_idx,
    output logic              hit,
    output logic [WORD_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [AW-1:0]     fill_idx,
    input  logic [WORD_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data
);

    logic              valid;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] data;

    assign hit      = valid && (idx == lookup_idx);
    assign hit_data = data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            idx   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            idx   <= fill_idx;
            data  <= fill_data;
        end else if (wr_en && valid && (idx == wr_idx)) begin
            data  <= wr_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory request responder: fixed-latency backing word store behind a
// single-entry hit buffer, answering with Done/Stall/CacheHit/err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Addr,
    input  logic [WORD_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    input  logic              createdump,
    output logic [WORD_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    logic [WORD_W-1:0] mem [2**AW];

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [AW-1:0]     req_idx;
    logic [WORD_W-1:0] req_data;
    op_t               req_op;

    logic [AW-1:0]     idx;
    logic              start;
    logic              mem_we;
    logic              fill_en;
    logic              buf_hit;
    logic [WORD_W-1:0] buf_data;

    // Upper address bits alias; createdump is reserved with no functional effect.
    logic unused_ok;
    assign unused_ok = ^{createdump, Addr[15:AW+1]};

    assign idx = Addr[AW:1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        mem_we    = 1'b0;
        fill_en   = 1'b0;
        DataOut   = '0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (Rd | Wr) begin
                    if (req_bad(Rd, Wr, Addr[0])) begin
                        err = 1'b1;
                    end else if (Rd && buf_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = buf_data;
                    end else begin
                        Stall     = 1'b1;
                        start     = 1'b1;
                        cnt_nxt   = LAT_M1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    Stall   = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    Done      = 1'b1;
                    state_nxt = IDLE;
                    if (req_op == OP_RD) begin
                        DataOut = mem[req_idx];
                        fill_en = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset silences every output and blocks any side effect.
        if (rst) begin
            start    = 1'b0;
            mem_we   = 1'b0;
            fill_en  = 1'b0;
            DataOut  = '0;
            Done     = 1'b0;
            Stall    = 1'b0;
            CacheHit = 1'b0;
            err      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_idx  <= '0;
            req_data <= '0;
            req_op   <= OP_RD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                req_idx  <= idx;
                req_data <= DataIn;
                req_op   <= Wr ? OP_WR : OP_RD;
            end
        end
    end

    // Backing store is never cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem[req_idx] <= req_data;
    end

    mem_hit_buffer #(.AW(AW)) u_hit_buffer (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (idx),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (fill_en),
        .fill_idx   (req_idx),
        .fill_data  (mem[req_idx]),
        .wr_en      (mem_we),
        .wr_idx     (req_idx),
        .wr_data    (req_data)
    );

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the instruction/data memory request interface used by the fetch stage: accepts Rd/Wr requests on Addr, answers with Done/Stall/CacheHit/err and DataOut.
- Models a multi-cycle backing word memory with fixed latency, fronted by a single-entry read hit buffer, so requesters see both zero-wait hits and stalled misses.
- Drop-in peer for any stage that holds Addr/Rd/Wr stable until Done or err.

Parameters:
- AW, 8, word-index bits; storage depth 2^AW 16-bit words; byte address bits [AW:1] index, bit 0 alignment, upper bits ignored (aliasing).
- LATENCY, 4, cycles from miss/write acceptance to Done; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Addr  in  16  byte address of request.
- DataIn  in  16  write data.
- Rd  in  1  read request, level, held by requester until Done/err.
- Wr  in  1  write request, level, held until Done/err.
- createdump  in  1  reserved; no functional effect in RTL.
- DataOut  out  16  read data, valid only when Done=1 and request was Rd; 0 otherwise.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  responder busy; request not yet complete.
- CacheHit  out  1  completing read was served from hit buffer; only meaningful with Done.
- err  out  1  request rejected this cycle.

Behaviour:
- Reset: state IDLE, hit buffer invalid, counter 0; while rst=1 all outputs 0 regardless of inputs. Memory array not cleared. rst mid-WAIT aborts the request; no memory write occurs.
- States: IDLE, WAIT.
- err (IDLE only, combinational): Rd&Wr both 1, or (Rd|Wr) with Addr[0]=1 -> err=1, Done=0, Stall=0, no state change, no access.
- Read hit (IDLE, Rd, valid, buffer addr == Addr[AW:1]): same cycle Done=1, CacheHit=1, DataOut=buffer data, Stall=0; stay IDLE.
- Read miss or legal write (IDLE): Stall=1 combinationally that cycle; capture word index, DataIn, op into request regs; counter <= LATENCY-1; -> WAIT.
- WAIT: Stall=1, Done=0 while counter != 0; counter decrements each cycle. Rd/Wr/Addr/DataIn ignored (captured copies used).
- WAIT with counter==0: Done=1, Stall=0, CacheHit=0; read -> DataOut=mem[req idx], buffer <= {valid, idx, data}; write -> mem[req idx] <= req data at edge, DataOut=0, if buffer valid and idx matches, buffer data <= req data. -> IDLE.
- Latency: miss/write issued in cycle t completes with Done in cycle t+LATENCY; LATENCY=1 gives WAIT of one cycle.
- Back-to-back: requester may present a new request in the cycle after Done; it is evaluated in IDLE normally (a hit after fill completes same cycle).
- Done, err, Stall mutually exclusive in every cycle.

Decomposition:
- Shared package: state encoding (IDLE, WAIT), op encoding (OP_RD, OP_WR), width constants (WORD_W=16).
- One natural sub-module: mem_hit_buffer (valid/idx/data registers, compare, update-on-fill and write-update ports). Storage array and FSM stay in the top.

Test Plan:
- Reset then Rd Addr=0x0010 (mem[8]=0xBEEF preloaded), LATENCY=4 -> Stall=1 cycles t..t+3, Done=1 CacheHit=0 DataOut=0xBEEF at t+4.
- Repeat Rd 0x0010 next cycle -> Done=1 CacheHit=1 DataOut=0xBEEF same cycle, Stall=0.
- Wr 0x0010 DataIn=0x1234 -> Done at t+4 DataOut=0; then Rd 0x0010 -> hit, DataOut=0x1234 same cycle.
- Rd 0x0011 -> err=1 same cycle, Done=0 Stall=0; Rd=Wr=1 at 0x0020 -> err=1, memory and buffer unchanged.
- Rd miss 0x0040, change Addr to 0x0050 mid-WAIT -> Done at t+4 returns mem[0x20] data; AW=8 alias: Rd 0x0210 returns mem[8].
- Assert rst at t+2 of a Wr miss -> outputs 0 immediately, IDLE after release, subsequent Rd shows old value (write aborted), buffer miss.
